// File: rtl/video_capture111.sv
// Frame capture sink for a 1-bit-per-channel parallel video stream.
// After an arm request, one full frame of the selected colour channel is
// captured and packed 16 pixels per word (LSB first) onto a write port.
module video_capture111 #(
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480,
    parameter int CHANNEL = 0,
    parameter int VS_POL  = 0,
    parameter int AW      = 16,
    parameter int BASE    = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          red,
    input  logic          grn,
    input  logic          blu,
    input  logic          vsync,
    input  logic          active,
    input  logic          arm,
    output logic          busy,
    output logic          done,
    output logic          err_len,
    output logic          err_short,
    output logic [AW-1:0] waddr,
    output logic [15:0]   wdata,
    output logic          we
);

    localparam int PW = $clog2(HACTIVE + 1);
    localparam int LW = $clog2(VACTIVE + 1);

    localparam logic [PW-1:0] PIX_MAX   = '1;
    localparam logic [PW-1:0] PIX_LINE  = PW'(HACTIVE);
    localparam logic [LW-1:0] LINE_LAST = LW'(VACTIVE);
    localparam logic [AW-1:0] ADDR_BASE = AW'(BASE);
    localparam logic          VS_LVL    = (VS_POL != 0);

    typedef enum logic [1:0] {
        StIdle,
        StWaitVs,
        StCapture,
        StDone
    } state_e;

    state_e        state;
    logic          red_s1, grn_s1, blu_s1, vs_s1, act_s1;
    logic          vs_prev, act_prev;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [15:0]   shreg;

    logic          pix_bit;
    logic          vs_assert;
    logic          line_end;
    logic          partial;
    logic [LW-1:0] line_next;

    // Channel select, edge detection and line bookkeeping from stage-1 values.
    always_comb begin
        pix_bit = red_s1;
        if (CHANNEL == 1) begin
            pix_bit = grn_s1;
        end else if (CHANNEL == 2) begin
            pix_bit = blu_s1;
        end
        vs_assert = (vs_s1 == VS_LVL) && (vs_prev != VS_LVL);
        line_end  = act_prev && !act_s1;
        partial   = (pix_cnt[3:0] != 4'd0);
        line_next = line_cnt + LW'(1);
    end

    // Input stage, capture FSM, packing and write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            red_s1    <= 1'b0;
            grn_s1    <= 1'b0;
            blu_s1    <= 1'b0;
            vs_s1     <= 1'b0;
            act_s1    <= 1'b0;
            vs_prev   <= 1'b0;
            act_prev  <= 1'b0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
            err_short <= 1'b0;
            waddr     <= ADDR_BASE;
            wdata     <= '0;
            we        <= 1'b0;
        end else begin
            red_s1   <= red;
            grn_s1   <= grn;
            blu_s1   <= blu;
            vs_s1    <= vsync;
            act_s1   <= active;
            vs_prev  <= vs_s1;
            act_prev <= act_s1;

            we <= 1'b0;
            // Address advances the cycle after each strobe.
            if (we) begin
                waddr <= waddr + AW'(1);
            end

            case (state)
                StIdle: begin
                    if (arm) begin
                        busy  <= 1'b1;
                        state <= StWaitVs;
                    end
                end

                StWaitVs: begin
                    if (vs_assert) begin
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        shreg    <= '0;
                        state    <= StCapture;
                    end
                end

                StCapture: begin
                    if (line_end) begin
                        if (partial) begin
                            wdata <= shreg;
                            we    <= 1'b1;
                            shreg <= '0;
                        end
                        if (pix_cnt != PIX_LINE) begin
                            err_len <= 1'b1;
                        end
                        pix_cnt  <= '0;
                        line_cnt <= line_next;
                        if (line_next == LINE_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end else if (vs_assert) begin
                            err_short <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= StDone;
                        end
                    end else if (vs_assert) begin
                        // Frame ended early: emit what has been gathered.
                        if (partial) begin
                            wdata <= shreg;
                            we    <= 1'b1;
                            shreg <= '0;
                        end
                        err_short <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= StDone;
                    end else if (act_s1) begin
                        if (pix_cnt[3:0] == 4'd15) begin
                            wdata <= {pix_bit, shreg[14:0]};
                            we    <= 1'b1;
                            shreg <= '0;
                        end else begin
                            shreg[pix_cnt[3:0]] <= pix_bit;
                        end
                        // Saturate so an overlong line can never alias to HACTIVE.
                        if (pix_cnt != PIX_MAX) begin
                            pix_cnt <= pix_cnt + PW'(1);
                        end
                    end
                end

                StDone: begin
                    if (arm) begin
                        done      <= 1'b0;
                        err_len   <= 1'b0;
                        err_short <= 1'b0;
                        waddr     <= ADDR_BASE;
                        busy      <= 1'b1;
                        state     <= StWaitVs;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_video_capture111.sv
// Randomized self-checking bench for video_capture111 using three instances
// with different geometry, channel, polarity, address width and base.
module tb_video_capture111;

    logic clk = 1'b0;
    logic reset, red, grn, blu, vsync, active;
    logic vsync_inv;
    logic arm0, arm1, arm2;

    logic        busy0, done0, el0, es0, we0;
    logic [15:0] waddr0, wdata0;
    logic        busy1, done1, el1, es1, we1;
    logic [1:0]  waddr1;
    logic [15:0] wdata1;
    logic        busy2, done2, el2, es2, we2;
    logic [7:0]  waddr2;
    logic [15:0] wdata2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t16 = 0;

    // Frame description shared by the driver and the reference model.
    int         nlines;
    int         llen [16];
    logic [2:0] px [16][64];

    logic [31:0] q0[$], q1[$], q2[$];
    int          q0c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign vsync_inv = ~vsync;

    video_capture111 #(
        .HACTIVE(48), .VACTIVE(6), .CHANNEL(0), .VS_POL(0), .AW(16), .BASE(0)
    ) u0 (
        .clk(clk), .reset(reset), .red(red), .grn(grn), .blu(blu), .vsync(vsync),
        .active(active), .arm(arm0), .busy(busy0), .done(done0), .err_len(el0),
        .err_short(es0), .waddr(waddr0), .wdata(wdata0), .we(we0)
    );

    video_capture111 #(
        .HACTIVE(20), .VACTIVE(2), .CHANNEL(1), .VS_POL(1), .AW(2), .BASE(2)
    ) u1 (
        .clk(clk), .reset(reset), .red(red), .grn(grn), .blu(blu), .vsync(vsync_inv),
        .active(active), .arm(arm1), .busy(busy1), .done(done1), .err_len(el1),
        .err_short(es1), .waddr(waddr1), .wdata(wdata1), .we(we1)
    );

    video_capture111 #(
        .HACTIVE(32), .VACTIVE(4), .CHANNEL(2), .VS_POL(0), .AW(8), .BASE(200)
    ) u2 (
        .clk(clk), .reset(reset), .red(red), .grn(grn), .blu(blu), .vsync(vsync),
        .active(active), .arm(arm2), .busy(busy2), .done(done2), .err_len(el2),
        .err_short(es2), .waddr(waddr2), .wdata(wdata2), .we(we2)
    );

    // Write-port monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (we0) begin
            q0.push_back({waddr0, wdata0});
            q0c.push_back(cyc);
        end
        if (we1) q1.push_back({14'd0, waddr1, wdata1});
        if (we2) q2.push_back({8'd0, waddr2, wdata2});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_arm(input int idx, input logic val);
        case (idx)
            0: arm0 = val;
            1: arm1 = val;
            2: arm2 = val;
            default: ;
        endcase
    endtask

    task automatic pulse_arm(input int idx);
        set_arm(idx, 1'b1);
        tick();
        set_arm(idx, 1'b0);
    endtask

    // mode 0: random, 1: all channels = x^y parity, 2: all ones.
    task automatic gen_frame(input int nl, input int len, input int mode);
        nlines = nl;
        for (int l = 0; l < 16; l++) begin
            llen[l] = len;
            for (int x = 0; x < 64; x++) begin
                case (mode)
                    0:       px[l][x] = 3'($urandom_range(0, 7));
                    1:       px[l][x] = {3{1'((x ^ l) & 1)}};
                    default: px[l][x] = 3'b111;
                endcase
            end
        end
    endtask

    task automatic drive_frame(input int arm_idx, input int arm_line, input bit trail);
        repeat (4) tick();
        vsync = 1'b0;
        repeat (3) tick();
        vsync = 1'b1;
        repeat (4) tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == arm_line) pulse_arm(arm_idx);
            repeat (4) tick();
            for (int x = 0; x < llen[l]; x++) begin
                active = 1'b1;
                red    = px[l][x][0];
                grn    = px[l][x][1];
                blu    = px[l][x][2];
                if (l == 0 && x == 15) t16 = cyc;
                tick();
            end
            active = 1'b0;
            red    = 1'b0;
            grn    = 1'b0;
            blu    = 1'b0;
        end
        repeat (4) tick();
        if (trail) begin
            vsync = 1'b0;
            repeat (3) tick();
            vsync = 1'b1;
        end
        repeat (6) tick();
    endtask

    // Reference: chop each captured line into zero-padded 16-pixel groups.
    task automatic compare_cap(input int idx, input int h, input int v, input int ch,
                               input int aw, input int base, input string tag);
        logic [31:0] got[$];
        logic [31:0] exp[$];
        logic [15:0] w;
        logic        b, d, el, es, exp_el, exp_es;
        int          addr, nl;
        case (idx)
            0:       begin got = q0; b = busy0; d = done0; el = el0; es = es0; end
            1:       begin got = q1; b = busy1; d = done1; el = el1; es = es1; end
            default: begin got = q2; b = busy2; d = done2; el = el2; es = es2; end
        endcase
        addr   = base;
        nl     = (nlines < v) ? nlines : v;
        exp_es = (nlines < v);
        exp_el = 1'b0;
        for (int l = 0; l < nl; l++) begin
            if (llen[l] != h) exp_el = 1'b1;
            for (int g = 0; g * 16 < llen[l]; g++) begin
                w = '0;
                for (int i = 0; i < 16; i++) begin
                    if (g * 16 + i < llen[l]) w[i] = px[l][g * 16 + i][ch];
                end
                exp.push_back({addr[15:0], w});
                addr = (addr + 1) % (1 << aw);
            end
        end
        check_eq({tag, "_nwr"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check_eq({tag, "_wr"}, got[i], exp[i]);
        end
        check_eq({tag, "_busy"}, {31'd0, b}, 0);
        check_eq({tag, "_done"}, {31'd0, d}, 1);
        check_eq({tag, "_errlen"}, {31'd0, el}, {31'd0, exp_el});
        check_eq({tag, "_errshort"}, {31'd0, es}, {31'd0, exp_es});
    endtask

    initial begin
        reset  = 1'b1;
        red    = 1'b0;
        grn    = 1'b0;
        blu    = 1'b0;
        vsync  = 1'b1;
        active = 1'b0;
        arm0   = 1'b0;
        arm1   = 1'b0;
        arm2   = 1'b0;
        repeat (3) tick();

        check_eq("rst_busy", {31'd0, busy0}, 0);
        check_eq("rst_done", {31'd0, done0}, 0);
        check_eq("rst_errlen", {31'd0, el0}, 0);
        check_eq("rst_errshort", {31'd0, es0}, 0);
        check_eq("rst_we", {31'd0, we0}, 0);
        check_eq("rst_waddr0", {16'd0, waddr0}, 0);
        check_eq("rst_wdata0", {16'd0, wdata0}, 0);
        check_eq("rst_waddr1", {30'd0, waddr1}, 2);
        check_eq("rst_waddr2", {24'd0, waddr2}, 200);
        reset = 1'b0;
        tick();

        // Parity pattern: even lines 0xAAAA, odd lines 0x5555.
        q0.delete();
        q0c.delete();
        pulse_arm(0);
        check_eq("arm_busy", {31'd0, busy0}, 1);
        gen_frame(6, 48, 1);
        drive_frame(-1, -1, 1'b0);
        compare_cap(0, 48, 6, 0, 16, 0, "parity");
        check_eq("parity_w0", q0.size() > 0 ? {16'd0, q0[0][15:0]} : 32'hFFFF_FFFF, 32'hAAAA);
        check_eq("latency", q0c.size() > 0 ? q0c[0] - t16 : -1, 2);

        // Random frames; the last one carries a short line.
        for (int i = 0; i < 3; i++) begin
            q0.delete();
            pulse_arm(0);
            gen_frame(6, 48, 0);
            if (i == 2) llen[$urandom_range(0, 5)] = 48 - $urandom_range(1, 15);
            drive_frame(-1, -1, 1'b0);
            compare_cap(0, 48, 6, 0, 16, 0, "rand");
        end

        // Green channel, 20-pixel lines: full word plus padded flush, address wraps.
        q1.delete();
        pulse_arm(1);
        gen_frame(2, 20, 2);
        drive_frame(-1, -1, 1'b0);
        compare_cap(1, 20, 2, 1, 2, 2, "flush");

        // One line one pixel short.
        q2.delete();
        pulse_arm(2);
        gen_frame(4, 32, 0);
        llen[2] = 31;
        drive_frame(-1, -1, 1'b0);
        compare_cap(2, 32, 4, 2, 8, 200, "len31");

        // Early vsync after two lines, then re-arm clears flags.
        q2.delete();
        pulse_arm(2);
        gen_frame(2, 32, 0);
        llen[1] = 27;
        drive_frame(-1, -1, 1'b1);
        compare_cap(2, 32, 4, 2, 8, 200, "short");
        pulse_arm(2);
        check_eq("rearm_done", {31'd0, done2}, 0);
        check_eq("rearm_errshort", {31'd0, es2}, 0);
        check_eq("rearm_errlen", {31'd0, el2}, 0);
        check_eq("rearm_busy", {31'd0, busy2}, 1);
        check_eq("rearm_waddr", {24'd0, waddr2}, 200);

        // Overlong line after re-arm.
        q2.delete();
        gen_frame(4, 32, 0);
        llen[1] = 40;
        drive_frame(-1, -1, 1'b0);
        compare_cap(2, 32, 4, 2, 8, 200, "long");

        // Arm mid-frame: that frame is skipped; a second arm during capture is ignored.
        q0.delete();
        gen_frame(6, 48, 0);
        drive_frame(0, 2, 1'b0);
        check_eq("midarm_nowr", q0.size(), 0);
        check_eq("midarm_busy", {31'd0, busy0}, 1);
        gen_frame(6, 48, 0);
        drive_frame(0, 3, 1'b0);
        compare_cap(0, 48, 6, 0, 16, 0, "midarm");

        // Reset after three writes.
        q0.delete();
        pulse_arm(0);
        gen_frame(6, 48, 0);
        fork
            drive_frame(-1, -1, 1'b0);
            begin
                int n = 0;
                int guard = 0;
                while (n < 3 && guard < 5000) begin
                    @(negedge clk);
                    if (we0) n++;
                    guard++;
                end
                check_eq("rst_wait", n, 3);
                reset = 1'b1;
                @(negedge clk);
                check_eq("midrst_busy", {31'd0, busy0}, 0);
                check_eq("midrst_we", {31'd0, we0}, 0);
                check_eq("midrst_waddr", {16'd0, waddr0}, 0);
                check_eq("midrst_done", {31'd0, done0}, 0);
                reset = 1'b0;
            end
        join
        check_eq("midrst_nwr", q0.size(), 3);

        q0.delete();
        pulse_arm(0);
        gen_frame(6, 48, 0);
        drive_frame(-1, -1, 1'b0);
        compare_cap(0, 48, 6, 0, 16, 0, "postrst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
